router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 16 +
 rtl/router_pkt_tx_if.sv | 29 ++
 rtl/router_tx_buf.sv | 19 +
 rtl/router_pkt_tx.sv | 130 +++++++++++++
 tb/tb_router_pkt_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared widths, header layout and FSM states for router_pkt_tx
package router_pkg;
    localparam int ADDR_W = 2;
    localparam int LEN_W = 6;
    localparam int DATA_W = 8;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB = ADDR_W;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP} state_e;
    function automatic logic [DATA_W-1:0] make_hdr(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] h;
        h = '0;
        h[HDR_LEN_LSB +: LEN_W] = len;
        h[HDR_ADDR_LSB +: ADDR_W] = addr;
        return h;
    endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: source and router side signals of router_pkt_tx
// err_inj exists only with ROUTER_TX_PARITY_ERR_INJ_EN defined
interface router_pkt_tx_if;
    import router_pkg::*;
    logic start;
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0] pay_len;
    logic [DATA_W-1:0] pl_data;
    logic pl_valid;
    logic pl_ready;
    logic busy;
    logic pkt_valid;
    logic [DATA_W-1:0] data_out;
    logic tx_active;
    logic done;
    logic cmd_err;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    logic err_inj;
    modport master(output start, dest_addr, pay_len, pl_data, pl_valid, busy, err_inj,
                   input pl_ready, pkt_valid, data_out, tx_active, done, cmd_err);
    modport slave(input start, dest_addr, pay_len, pl_data, pl_valid, busy, err_inj,
                  output pl_ready, pkt_valid, data_out, tx_active, done, cmd_err);
`else
    modport master(output start, dest_addr, pay_len, pl_data, pl_valid, busy,
                   input pl_ready, pkt_valid, data_out, tx_active, done, cmd_err);
    modport slave(input start, dest_addr, pay_len, pl_data, pl_valid, busy,
                  output pl_ready, pkt_valid, data_out, tx_active, done, cmd_err);
`endif
endinterface

// File: rtl/router_tx_buf.sv
// router_tx_buf: payload store, single write port, asynchronous read, no reset
module router_tx_buf #(
    parameter int DEPTH = 63,
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one packet payload, then sends header, payload, parity and an idle gap
// ROUTER_TX_PARITY_ERR_INJ_EN adds err_inj, which flips bit 0 of the parity byte
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int IDLE_GAP = 2,
    parameter int MAX_LEN = 63
) (
    input logic clock,
    input logic reset,
    router_pkt_tx_if.slave bus
);
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
    state_e state_q, state_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] par_q, par_d, data_out_q, data_out_d, rd_data;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic pkt_valid_q, pkt_valid_d, done_q, done_d, cmd_err_q, cmd_err_d, inj_q, inj_d, we, legal;

    router_tx_buf #(.DEPTH(MAX_LEN), .AW(LEN_W), .DW(DATA_W)) u_buf (
        .clock(clock),
        .we(we),
        .waddr(wr_cnt_q),
        .wdata(bus.pl_data),
        .raddr(rd_cnt_d),
        .rdata(rd_data)
    );

    assign legal = bus.dest_addr != 2'd3 && bus.pay_len != '0 && int'(bus.pay_len) <= MAX_LEN;
    assign we = state_q == S_LOAD && bus.pl_valid;

    always_comb begin
        state_d = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        len_d = len_q;
        addr_d = addr_q;
        par_d = par_q;
        gap_cnt_d = gap_cnt_q;
        inj_d = inj_q;
        done_d = 1'b0;
        cmd_err_d = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                if (legal) begin
                    state_d = S_LOAD;
                    len_d = bus.pay_len;
                    addr_d = bus.dest_addr;
                    par_d = '0;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
                    inj_d = bus.err_inj;
`else
                    inj_d = 1'b0;
`endif
                end else cmd_err_d = 1'b1;
            end
            S_LOAD: if (bus.pl_valid) begin
                par_d = par_q ^ bus.pl_data;
                wr_cnt_d = wr_cnt_q + LEN_W'(1);
                state_d = wr_cnt_q == len_q - LEN_W'(1) ? S_HEADER : S_LOAD;
            end
            S_HEADER: if (!bus.busy) begin
                par_d = par_q ^ make_hdr(len_q, addr_q);
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: if (!bus.busy) begin
                state_d = rd_cnt_q == len_q - LEN_W'(1) ? S_PARITY : S_PAYLOAD;
                rd_cnt_d = rd_cnt_q == len_q - LEN_W'(1) ? rd_cnt_q : rd_cnt_q + LEN_W'(1);
            end
            S_PARITY: if (!bus.busy) begin
                state_d = S_GAP;
                gap_cnt_d = '0;
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                state_d = gap_cnt_q == GAP_LAST ? S_IDLE : S_GAP;
                done_d = gap_cnt_q == GAP_LAST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with the state they describe
    always_comb begin
        pkt_valid_d = state_d == S_HEADER || state_d == S_PAYLOAD;
        data_out_d = state_d == S_HEADER ? make_hdr(len_d, addr_d) :
                     state_d == S_PAYLOAD ? rd_data :
                     state_d == S_PARITY ? par_d ^ {7'd0, inj_d} : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            len_q <= '0;
            addr_q <= '0;
            par_q <= '0;
            gap_cnt_q <= '0;
            inj_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_out_q <= '0;
            done_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            len_q <= len_d;
            addr_q <= addr_d;
            par_q <= par_d;
            gap_cnt_q <= gap_cnt_d;
            inj_q <= inj_d;
            pkt_valid_q <= pkt_valid_d;
            data_out_q <= data_out_d;
            done_q <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign bus.pl_ready = state_q == S_LOAD;
    assign bus.tx_active = state_q != S_IDLE;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out = data_out_q;
    assign bus.done = done_q;
    assign bus.cmd_err = cmd_err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized packet bench for router_pkt_tx with a byte-sequence reference model
module tb_router_pkt_tx;
    localparam int IDLE_GAP = 2;
    localparam int MAX_LEN = 63;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [7:0] pay [64];

    router_pkt_tx_if bus();
    router_pkt_tx #(.IDLE_GAP(IDLE_GAP), .MAX_LEN(MAX_LEN)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit rnd, input int stall_k,
                            input int stall_n, input bit inj, input int rst_k);
        logic [7:0] exp_d [$];
        logic exp_v [$];
        logic [7:0] par;
        bit ie, v, r, b;
        int i, k, t, held;
        ie = inj;
`ifndef ROUTER_TX_PARITY_ERR_INJ_EN
        ie = 1'b0;
`endif
        par = {l, a};
        exp_d.push_back({l, a});
        exp_v.push_back(1'b1);
        for (int j = 0; j < int'(l); j++) begin
            par = par ^ pay[j];
            exp_d.push_back(pay[j]);
            exp_v.push_back(1'b1);
        end
        exp_d.push_back(par ^ {7'd0, ie});
        exp_v.push_back(1'b0);
        @(negedge clock);
        bus.start = 1'b1;
        bus.dest_addr = a;
        bus.pay_len = l;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        bus.err_inj = ie;
`endif
        @(negedge clock);
        bus.start = 1'b0;
        compared++;
        if (bus.tx_active !== 1'b1 || bus.cmd_err !== 1'b0) begin
            mismatched++;
            $display("FAIL accept: tx_active=%b cmd_err=%b, required 1 0", bus.tx_active, bus.cmd_err);
        end
        i = 0;
        t = 0;
        while (i < int'(l) && t < 4000) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.pl_valid = v;
            bus.pl_data = pay[i];
            r = bus.pl_ready;
            if (rnd) bus.start = 1'($urandom_range(0, 1));
            compared++;
            if (r !== 1'b1) begin
                mismatched++;
                $display("FAIL pl_ready byte %0d: got %b, required 1", i, r);
                break;
            end
            @(negedge clock);
            if (v && r) i++;
            t++;
        end
        bus.pl_valid = 1'b0;
        bus.start = 1'b0;
        if (i < int'(l)) return;
        k = 0;
        t = 0;
        held = 0;
        while (k < exp_d.size() && t < 4000) begin
            compared++;
            if (bus.pkt_valid !== exp_v[k] || bus.data_out !== exp_d[k] || bus.tx_active !== 1'b1) begin
                mismatched++;
                $display("FAIL out[%0d]: valid=%b data=%h act=%b, required %b %h 1", k, bus.pkt_valid, bus.data_out,
                         bus.tx_active, exp_v[k], exp_d[k]);
            end
            if (k == rst_k) begin
                #2 reset = 1'b1;
                #1;
                compared++;
                if (bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.tx_active !== 1'b0 || bus.pl_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL async_reset: valid=%b data=%h act=%b rdy=%b, required 0 00 0 0", bus.pkt_valid,
                             bus.data_out, bus.tx_active, bus.pl_ready);
                end
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (k == stall_k) held++;
            b = (k == stall_k && held <= stall_n) ? 1'b1 : rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            bus.busy = b;
            if (rnd) bus.start = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (!b) k++;
            t++;
        end
        bus.busy = 1'b0;
        bus.start = 1'b0;
        if (k < exp_d.size()) begin
            mismatched++;
            $display("FAIL out_timeout: reached %0d, required %0d", k, exp_d.size());
        end
        if (stall_k >= 0) begin
            compared++;
            if (held !== stall_n + 1) begin
                mismatched++;
                $display("FAIL stall_hold: got %0d cycles, required %0d", held, stall_n + 1);
            end
        end
        for (int g = 0; g < IDLE_GAP; g++) begin
            compared++;
            if (bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.tx_active !== 1'b1 || bus.done !== 1'b0) begin
                mismatched++;
                $display("FAIL gap[%0d]: valid=%b data=%h act=%b done=%b, required 0 00 1 0", g, bus.pkt_valid,
                         bus.data_out, bus.tx_active, bus.done);
            end
            bus.busy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
        end
        bus.busy = 1'b0;
        compared++;
        if (bus.done !== 1'b1 || bus.tx_active !== 1'b0 || bus.pkt_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL done_pulse: done=%b act=%b valid=%b, required 1 0 0", bus.done, bus.tx_active, bus.pkt_valid);
        end
        @(negedge clock);
        compared++;
        if (bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_width: got %b, required 0", bus.done);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        compared++;
        if (bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.pl_ready !== 1'b0 || bus.tx_active !== 1'b0 ||
            bus.done !== 1'b0 || bus.cmd_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b data=%h rdy=%b act=%b done=%b err=%b, required all 0", bus.pkt_valid,
                     bus.data_out, bus.pl_ready, bus.tx_active, bus.done, bus.cmd_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, -1);
    endtask

    task automatic test_busy;
        send_pkt(2'd1, 6'd3, 1'b0, 2, 4, 1'b0, -1);
    endtask

    task automatic test_cmd_err;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.dest_addr = i == 0 ? 2'd3 : 2'd2;
            bus.pay_len = i == 0 ? 6'd5 : 6'd0;
            @(negedge clock);
            bus.start = 1'b0;
            compared++;
            if (bus.cmd_err !== 1'b1 || bus.tx_active !== 1'b0 || bus.pl_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL cmd_err[%0d]: err=%b act=%b rdy=%b, required 1 0 0", i, bus.cmd_err, bus.tx_active,
                         bus.pl_ready);
            end
            @(negedge clock);
            compared++;
            if (bus.cmd_err !== 1'b0 || bus.tx_active !== 1'b0) begin
                mismatched++;
                $display("FAIL cmd_err_width[%0d]: err=%b act=%b, required 0 0", i, bus.cmd_err, bus.tx_active);
            end
        end
    endtask

    task automatic test_max_len;
        for (int j = 0; j < 63; j++) pay[j] = 8'(j);
        send_pkt(2'd0, 6'd63, 1'b0, -1, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid;
        for (int j = 0; j < 8; j++) pay[j] = 8'($urandom);
        send_pkt(2'd2, 6'd8, 1'b0, -1, 0, 1'b0, 3);
        test_basic();
    endtask

    task automatic test_err_inj;
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, -1, 0, 1'b1, -1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 63; j++) pay[j] = 8'($urandom);
            send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, MAX_LEN)), 1'b1, -1, 0, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dest_addr = '0;
        bus.pay_len = '0;
        bus.pl_data = '0;
        bus.pl_valid = 1'b0;
        bus.busy = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        bus.err_inj = 1'b0;
`endif
        test_reset();
        test_basic();
        test_busy();
        test_cmd_err();
        test_max_len();
        test_reset_mid();
        test_err_inj();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
